// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result stage:
//   - FLAG_N/FLAG_Z/FLAG_V/FLAG_C : bit positions inside a 4-bit flag vector
//   - cond_e                      : 4-bit condition-code encoding
//   - buf_state_e                 : occupancy of the two-entry result buffer
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_C = 0;

  typedef enum logic [3:0] {
    COND_EQ   = 4'd0,
    COND_NE   = 4'd1,
    COND_CS   = 4'd2,
    COND_CC   = 4'd3,
    COND_MI   = 4'd4,
    COND_PL   = 4'd5,
    COND_VS   = 4'd6,
    COND_VC   = 4'd7,
    COND_GT   = 4'd8,
    COND_LT   = 4'd9,
    COND_GE   = 4'd10,
    COND_LE   = 4'd11,
    COND_NV12 = 4'd12,
    COND_NV13 = 4'd13,
    COND_AL   = 4'd14,
    COND_NV15 = 4'd15
  } cond_e;

  // Encoding equals the number of held entries.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } buf_state_e;

endpackage

// File: rtl/alu_result_stage_cond_eval.sv
// -----------------------------------------------------------------------------
// cond_eval
// Combinational condition-code evaluator.
// Ports:
//   flags [3:0] in  : flag vector {N,Z,V,C}
//   cond  [3:0] in  : condition code (cond_e)
//   pass        out : 1 when the condition holds; codes 12, 13, 15 never pass
// -----------------------------------------------------------------------------
module cond_eval
  import alu_pkg::*;
(
  input  logic [3:0] flags,
  input  logic [3:0] cond,
  output logic       pass
);

  logic n, z, v, c;

  assign n = flags[FLAG_N];
  assign z = flags[FLAG_Z];
  assign v = flags[FLAG_V];
  assign c = flags[FLAG_C];

  always_comb begin
    pass = 1'b0;
    case (cond_e'(cond))
      COND_EQ: pass = z;
      COND_NE: pass = !z;
      COND_CS: pass = c;
      COND_CC: pass = !c;
      COND_MI: pass = n;
      COND_PL: pass = !n;
      COND_VS: pass = v;
      COND_VC: pass = !v;
      COND_GT: pass = !z && (n == v);
      COND_LT: pass = (n != v);
      COND_GE: pass = (n == v);
      COND_LE: pass = z || (n != v);
      COND_AL: pass = 1'b1;
      default: pass = 1'b0;
    endcase
  end

endmodule

// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
// Writeback-side buffer for ALU results: a two-entry FIFO (main + skid) that
// also owns the architectural flag register. Optional conditional execution
// is enabled by defining ALU_RESULT_STAGE_COND_EXEC_EN; without it, cond is
// ignored and every instruction passes.
//
// Handshake: a transfer happens on any rising edge where valid && ready are
// both high on that side; valid must not depend on ready, payload is held
// stable while valid && !ready.
//
// Ports:
//   clk, rst                 : clock, synchronous active-high reset
//   in_valid / in_ready      : input handshake (in_ready = buffer not full)
//   alu_result [N-1:0]       : ALU result
//   alu_flags  [3:0]         : {N,Z,V,C}
//   rd_addr [3:0], wr_en     : destination register and write enable
//   set_flags                : instruction updates flags_q
//   cond [3:0]               : condition code
//   flush                    : squash held and incoming entries
//   out_valid / out_ready    : writeback handshake
//   out_result/out_rd/out_wr_en : writeback payload (head entry)
//   flags_q [3:0]            : architectural flag register
//   dbg_state_o              : buffer occupancy state, for observation
// -----------------------------------------------------------------------------
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] alu_result,
  input  logic [3:0]   alu_flags,
  input  logic [3:0]   rd_addr,
  input  logic         wr_en,
  input  logic         set_flags,
  input  logic [3:0]   cond,
  input  logic         flush,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_result,
  output logic [3:0]   out_rd,
  output logic         out_wr_en,
  output logic [3:0]   flags_q,
  output buf_state_e   dbg_state_o
);

  buf_state_e   state_q;
  logic [N-1:0] main_result_q, skid_result_q;
  logic [3:0]   main_rd_q, skid_rd_q;
  logic         main_wr_q, skid_wr_q;
  logic [3:0]   flags_reg_q;

  logic pass;
  logic accept;
  logic drain;
  logic in_wr;

`ifdef ALU_RESULT_STAGE_COND_EXEC_EN
  cond_eval u_cond_eval (
    .flags (flags_reg_q),
    .cond  (cond),
    .pass  (pass)
  );
`else
  logic unused_cond;
  assign unused_cond = ^cond;
  assign pass        = 1'b1;
`endif

  assign in_ready    = (state_q != ST_TWO);
  assign out_valid   = (state_q != ST_EMPTY);
  assign accept      = in_valid && in_ready;
  assign drain       = out_valid && out_ready;
  // A failing condition still occupies a slot, but never writes rd.
  assign in_wr       = wr_en && pass;

  assign out_result  = main_result_q;
  assign out_rd      = main_rd_q;
  assign out_wr_en   = main_wr_q;
  assign flags_q     = flags_reg_q;
  assign dbg_state_o = state_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_EMPTY;
      main_result_q <= '0;
      main_rd_q     <= '0;
      main_wr_q     <= 1'b0;
      skid_result_q <= '0;
      skid_rd_q     <= '0;
      skid_wr_q     <= 1'b0;
      flags_reg_q   <= 4'b0000;
    end else if (flush) begin
      // Flush drops everything this cycle, including the incoming entry and
      // its flag update; flags written by earlier accepts are kept.
      state_q <= ST_EMPTY;
    end else begin
      if (accept && pass && set_flags) begin
        flags_reg_q <= alu_flags;
      end
      case (state_q)
        ST_EMPTY: begin
          if (accept) begin
            state_q       <= ST_ONE;
            main_result_q <= alu_result;
            main_rd_q     <= rd_addr;
            main_wr_q     <= in_wr;
          end
        end
        ST_ONE: begin
          if (accept && drain) begin
            main_result_q <= alu_result;
            main_rd_q     <= rd_addr;
            main_wr_q     <= in_wr;
          end else if (accept) begin
            state_q       <= ST_TWO;
            skid_result_q <= alu_result;
            skid_rd_q     <= rd_addr;
            skid_wr_q     <= in_wr;
          end else if (drain) begin
            state_q <= ST_EMPTY;
          end
        end
        ST_TWO: begin
          if (drain) begin
            state_q       <= ST_ONE;
            main_result_q <= skid_result_q;
            main_rd_q     <= skid_rd_q;
            main_wr_q     <= skid_wr_q;
          end
        end
        default: state_q <= ST_EMPTY;
      endcase
    end
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 SHALL have parameter N, default 8, datapath width matching the ALU result.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port in_valid  in  1  ALU output valid this cycle.
REQ-005 SHALL have port in_ready  out  1  stage can accept an input.
REQ-006 SHALL have port alu_result  in  N  ALU result.
REQ-007 SHALL have port alu_flags  in  4  ALU flags: [3]=N, [2]=Z, [1]=V, [0]=C.
REQ-008 SHALL have port rd_addr  in  4  destination register index.
REQ-009 SHALL have port wr_en  in  1  instruction writes rd.
REQ-010 SHALL have port set_flags  in  1  instruction updates the flag register.
REQ-011 SHALL have port cond  in  4  condition code.
REQ-012 SHALL have port flush  in  1  squash all held and incoming entries.
REQ-013 SHALL have port out_valid  out  1  writeback entry valid.
REQ-014 SHALL have port out_ready  in  1  writeback consumes the entry.
REQ-015 SHALL have ports out_result (out, N), out_rd (out, 4) and out_wr_en (out, 1): writeback payload.
REQ-016 SHALL have port flags_q  out  4  architectural flag register, same bit order as alu_flags.

Function
REQ-017 Handshakes: input transfer when in_valid&&in_ready; output transfer when out_valid&&out_ready.
REQ-018 Two-entry buffer (main + skid); states EMPTY, ONE, TWO; in_ready = (state != TWO); out_valid = (state != EMPTY).
REQ-019 Transitions: EMPTY->ONE on accept; ONE->TWO on accept without drain; ONE->EMPTY on drain without accept; ONE stays ONE on simultaneous accept+drain; TWO->ONE on drain.
REQ-020 Latency: one cycle, input to out_valid when the stage is empty; order strictly FIFO.
REQ-021 Condition evaluated at accept against flags_q before that cycle's update. Codes: 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V; 8 GT !Z&&(N==V); 9 LT N!=V; 10 GE N==V; 11 LE Z||(N!=V); 14 AL; 12, 13, 15 never.
REQ-022 Condition pass: stored out_wr_en = wr_en; flags_q <= alu_flags when set_flags=1.
REQ-023 Condition fail: entry still enqueued with out_wr_en=0; flags_q unchanged.
REQ-024 Back-to-back accepts see the flags written by the previous accept; no extra bubble.
REQ-025 Flush: next cycle state=EMPTY, out_valid=0; an input presented in the flush cycle is not accepted and does not update flags; earlier flag updates are not undone.
REQ-026 Flush has priority over accept and drain in the same cycle.
REQ-027 Payload is stable while out_valid=1 and out_ready=0.

Reset
REQ-028 On rst: state=EMPTY, out_valid=0, out_result=0, out_rd=0, out_wr_en=0, flags_q=4'b0000; in_ready=1 in the cycle after reset.
REQ-029 rst mid-operation discards all held entries; rst has priority over flush.

Configuration
REQ-030 Macro ALU_RESULT_STAGE_COND_EXEC_EN: when defined, REQ-021..REQ-023 apply.
REQ-031 Without the macro, cond is ignored and every instruction passes.

Structure
REQ-032 Shared package alu_pkg holds the cond-code enum, flag bit index constants (FLAG_N=3, FLAG_Z=2, FLAG_V=1, FLAG_C=0) and the buffer-state enum.
REQ-033 Sub-module cond_eval (combinational; inputs flags and cond, output pass) implements REQ-021.

Verification
REQ-034 After reset, accept result 8'h05, cond AL, set_flags=1, flags 4'b0000 -> out_valid next cycle, out_result=8'h05, flags_q=4'b0000.
REQ-035 Set flags Z=1 (4'b0100), then send EQ with wr_en=1 and NE with wr_en=1 -> out_wr_en=1 for EQ, 0 for NE; flags_q stays 4'b0100.
REQ-036 Hold out_ready=0 and send 3 inputs -> in_ready=0 after 2 are accepted; raise out_ready -> entries drain in order 1,2,3 with no loss or duplication.
REQ-037 Hold ONE state with in_valid=1 and out_ready=1 continuously for 10 cycles -> one transfer per cycle, state stays ONE.
REQ-038 TWO state, assert flush together with in_valid=1 -> next cycle out_valid=0, in_ready=1; flags_q unchanged by the flushed input.
REQ-039 Build without ALU_RESULT_STAGE_COND_EXEC_EN, send cond=15 with wr_en=1 -> out_wr_en=1.
